// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: column strobes out, row returns in,
// and the debounced key report towards the downstream datapath.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debouncing.
// Columns are strobed one-hot-low, each for SCAN_DIV cycles; one full
// sweep of four columns forms a frame classified as NONE, ONE(code) or MULTI.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 3
) (
  input logic            clk,
  input logic            rst_n,
  keypad_scanner_if.master bus
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB     = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [1:0]    acc_n;      // keys seen so far this frame, saturating at 2
  logic [3:0]    acc_code;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [3:0]    cand, cand_d;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          accept;

  logic          sample, frame_tick, frame_none, frame_one;
  logic [3:0]    pressed, cur_code, frame_code;
  logic [2:0]    pop, sum;
  logic [1:0]    total;

  // Two-flop synchronizer for the asynchronous row returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= bus.row_n;
      row_s2 <= row_s1;
    end
  end

  // Combine the current column sample with the frame accumulator.
  always_comb begin
    sample   = (div == DIV_MAX);
    pressed  = ~row_s2;
    cur_code = {2'b00, col};
    pop      = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      pop = pop + {2'b00, pressed[r]};
      if (pressed[r]) cur_code = {2'(r), col};
    end
    sum        = {1'b0, acc_n} + pop;
    total      = (sum > 3'd1) ? 2'd2 : sum[1:0];
    frame_code = (acc_n == 2'd1) ? acc_code : cur_code;
    frame_tick = sample && (col == 2'd3);
    frame_none = (total == 2'd0);
    frame_one  = (total == 2'd1);
  end

  // Column divider and per-frame key accumulation; scanning never stops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      col      <= '0;
      acc_n    <= '0;
      acc_code <= '0;
    end else if (sample) begin
      div <= '0;
      col <= col + 2'd1;
      if (col == 2'd3) begin
        acc_n    <= '0;
        acc_code <= '0;
      end else begin
        acc_n    <= total;
        acc_code <= frame_code;
      end
    end else begin
      div <= div + DW'(1);
    end
  end

  // FSM state and debounce datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cand        <= cand_d;
      key_valid_q <= accept;
      if (accept) key_code_q <= cand_d;
    end
  end

  // Next-state logic, evaluated once per completed frame.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    accept  = 1'b0;
    cnt_inc = (cnt == DEB) ? cnt : cnt + CNT_ONE;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (frame_one) begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
            if (DEB <= CNT_ONE) accept = 1'b1;
            else                state_d = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (frame_one && frame_code == cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) accept = 1'b1;
          end else if (frame_one) begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_one && frame_code == key_code_q) begin
            state_d = HELD;
          end else if (frame_none) begin
            // A single-frame debounce releases on the first NONE frame.
            cnt_d   = CNT_ONE;
            state_d = (DEB <= CNT_ONE) ? IDLE : RELEASE_WAIT;
          end else begin
            cnt_d   = '0;
            state_d = RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (frame_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) state_d = IDLE;
          end else if (frame_one && frame_code == key_code_q) begin
            state_d = HELD;
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (accept) state_d = HELD;
    end
  end

  // Outputs: column strobe from the index, key report from FSM state.
  always_comb begin
    bus.col_n     = ~(4'b0001 << col);
    bus.key_code  = key_code_q;
    bus.key_valid = key_valid_q;
    bus.key_down  = (state == HELD) || (state == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3, 16-cycle frames).
// A keypad model drives row_n from col_n and a 16-bit pressed-key mask.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [15:0] K0 = 16'h0001;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K9 = 16'h0200;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  col_n;
    logic        key_down;
    logic [3:0]  key_code;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  vec_t tbl [32];
  exp_t sbq [$];

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Keypad model: a row reads low when a pressed key sits in the strobed column.
  always_comb begin
    bus.row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r + c] && !bus.col_n[c]) bus.row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cyc: got %0d expected %0d", cyc, n);
    end
  endtask

  // Scoreboard: every key_valid cycle must match the next expected press.
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse at cyc %0d: code %h expected no pulse", cyc, bus.key_code);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.key_code !== e.code || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL pulse: got code %h at cyc %0d expected code %h at cyc %0d",
                   bus.key_code, cyc, e.code, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one_hot;
    one_hot = 4'b0001;
    for (int i = 0; i < 32; i++) begin
      tbl[i].keys     = '0;
      tbl[i].col_n    = ~(one_hot << ((i / 4) % 4));
      tbl[i].key_down = 1'b0;
      tbl[i].key_code = 4'd0;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: column strobe sequence and quiet outputs.
    for (int i = 0; i < 32; i++) begin
      at_cyc(i);
      keys = tbl[i].keys;
      chk("col_n", {12'h0, bus.col_n}, {12'h0, tbl[i].col_n});
      chk("idle_down", {15'h0, bus.key_down}, {15'h0, tbl[i].key_down});
      chk("idle_code", {12'h0, bus.key_code}, {12'h0, tbl[i].key_code});
    end

    // Key 9 held from a frame boundary: accepted after the third frame.
    at_cyc(32);  keys = K9; sbq.push_back('{4'd9, 80});
    at_cyc(79);  chk("press_down_pre", {15'h0, bus.key_down}, 16'h0);
    at_cyc(80);  chk("press_down", {15'h0, bus.key_down}, 16'h1);
                 chk("press_code", {12'h0, bus.key_code}, 16'h9);
    at_cyc(128); chk("held_down", {15'h0, bus.key_down}, 16'h1);

    // One-frame release glitch, then a real release.
    keys = '0;
    at_cyc(144); keys = K9;
    at_cyc(145); chk("glitch_down", {15'h0, bus.key_down}, 16'h1);
    at_cyc(176); chk("glitch_down2", {15'h0, bus.key_down}, 16'h1);
    keys = '0;
    at_cyc(223); chk("release_pre", {15'h0, bus.key_down}, 16'h1);
    at_cyc(224); chk("release_down", {15'h0, bus.key_down}, 16'h0);
                 chk("release_code", {12'h0, bus.key_code}, 16'h9);

    // Bounce: two press frames, one empty frame, then stable press.
    at_cyc(240); keys = K9;
    at_cyc(272); keys = '0;
    at_cyc(288); keys = K9; sbq.push_back('{4'd9, 336});
    at_cyc(335); chk("bounce_pre", {15'h0, bus.key_down}, 16'h0);
    at_cyc(336); chk("bounce_down", {15'h0, bus.key_down}, 16'h1);

    // Two keys at once are ignored; releasing one accepts the other.
    at_cyc(352); keys = '0;
    at_cyc(400); chk("multi_idle", {15'h0, bus.key_down}, 16'h0);
    keys = K0 | K5;
    at_cyc(464); chk("multi_down", {15'h0, bus.key_down}, 16'h0);
    keys = K0; sbq.push_back('{4'd0, 512});
    at_cyc(511); chk("single_pre", {15'h0, bus.key_down}, 16'h0);
    at_cyc(512); chk("single_down", {15'h0, bus.key_down}, 16'h1);
                 chk("single_code", {12'h0, bus.key_code}, 16'h0);

    // Re-press key 9, then reset mid-frame while held.
    keys = '0;
    at_cyc(560); chk("k0_release", {15'h0, bus.key_down}, 16'h0);
    keys = K9; sbq.push_back('{4'd9, 608});
    at_cyc(608); chk("k9_down", {15'h0, bus.key_down}, 16'h1);
                 chk("k9_code", {12'h0, bus.key_code}, 16'h9);
    at_cyc(616); rst_n = 1'b0;
    at_cyc(0);   rst_n = 1'b1;
    chk("rst_col", {12'h0, bus.col_n}, 16'h000e);
    chk("rst_down", {15'h0, bus.key_down}, 16'h0);
    chk("rst_code", {12'h0, bus.key_code}, 16'h0);
    chk("rst_valid", {15'h0, bus.key_valid}, 16'h0);
    sbq.push_back('{4'd9, 48});
    at_cyc(47);  chk("reaccept_pre", {15'h0, bus.key_down}, 16'h0);
    at_cyc(48);  chk("reaccept_down", {15'h0, bus.key_down}, 16'h1);
                 chk("reaccept_code", {12'h0, bus.key_code}, 16'h9);
    at_cyc(60);  chk("pending_pulses", 16'(sbq.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
